// File: rtl/run_continue_conditioner.sv
// Conditions the raw Run and Continue pushbuttons for the LC-3 control unit.
// Each button passes through a polarity fix, a two-flop synchroniser and a
// counter-based debounce FSM. The result is a clean level output and a
// one-cycle press pulse per button. The two channels share no state.

// One button channel: synchroniser, debounce FSM and press-pulse generator.
module run_continue_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 20,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic pulse
);

  // Bit 1 of the state is the debounced level. Both "held" states have it
  // set, so the level output comes straight from a flop.
  localparam logic [1:0] IDLE         = 2'b00;
  localparam logic [1:0] PRESS_WAIT   = 2'b01;
  localparam logic [1:0] PRESSED      = 2'b10;
  localparam logic [1:0] RELEASE_WAIT = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Fix the polarity and bring the raw pin into the clock domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1. That
      // gives two real flop stages. Blocking assignments would collapse them
      // into one.
      sync1 <= btn ^ BTN_ACTIVE_LOW;
      sync2 <= sync1;
    end
  end

  // Debounce FSM. A change is accepted only after the synchronised input
  // has stayed stable for the full count. Any bounce returns the FSM to the
  // last stable state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign level = state[1];

endmodule

// Top level: two independent, identical button channels.
module run_continue_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 20,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic run_btn_i,
  input  logic continue_btn_i,
  output logic Run,
  output logic Continue,
  output logic Run_pulse,
  output logic Continue_pulse
);

  run_continue_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_run (
    .clk  (Clk),
    .rst_n(Reset),
    .btn  (run_btn_i),
    .level(Run),
    .pulse(Run_pulse)
  );

  run_continue_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_continue (
    .clk  (Clk),
    .rst_n(Reset),
    .btn  (continue_btn_i),
    .level(Continue),
    .pulse(Continue_pulse)
  );

endmodule

// File: tb/tb_run_continue_conditioner.sv
// Bench for run_continue_conditioner. It uses two instances: an active-high
// one and an active-low one. Both share the clock and reset.
// A reference model tracks each channel as "consecutive synchronised samples
// disagreeing with the level". After each rising edge it pushes the expected
// outputs into a queue. A monitor on the falling edge pops each entry and
// compares it with both instances.
module tb_run_continue_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_btn = 1'b0;
  logic cont_btn = 1'b0;
  logic al_run = 1'b1;
  logic al_cont = 1'b1;

  logic run_o, cont_o, run_p, cont_p;
  logic al_run_o, al_cont_o, al_run_p, al_cont_p;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb[$];

  always #5 clk = ~clk;

  run_continue_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut (
    .Clk           (clk),
    .Reset         (rst_n),
    .run_btn_i     (run_btn),
    .continue_btn_i(cont_btn),
    .Run           (run_o),
    .Continue      (cont_o),
    .Run_pulse     (run_p),
    .Continue_pulse(cont_p)
  );

  run_continue_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut_al (
    .Clk           (clk),
    .Reset         (rst_n),
    .run_btn_i     (al_run),
    .continue_btn_i(al_cont),
    .Run           (al_run_o),
    .Continue      (al_cont_o),
    .Run_pulse     (al_run_p),
    .Continue_pulse(al_cont_p)
  );

  // Reference model. Channel index: 0 run, 1 continue, 2 active-low run,
  // 3 active-low continue. A level flips after D+1 consecutive synchronised
  // samples that disagree with it. A press flip also emits a pulse.
  bit m_h1[4];
  bit m_h2[4];
  bit m_lvl[4];
  bit m_pul[4];
  int m_run[4];

  always @(posedge clk) begin
    bit pressed[4];
    pressed[0] = run_btn;
    pressed[1] = cont_btn;
    pressed[2] = ~al_run;
    pressed[3] = ~al_cont;
    for (int c = 0; c < 4; c++) begin
      bit s;
      if (!rst_n) begin
        m_h1[c] = 1'b0;
        m_h2[c] = 1'b0;
        m_lvl[c] = 1'b0;
        m_pul[c] = 1'b0;
        m_run[c] = 0;
      end else begin
        s = m_h2[c];
        m_h2[c] = m_h1[c];
        m_h1[c] = pressed[c];
        m_pul[c] = 1'b0;
        m_run[c] = (s != m_lvl[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == D + 1) begin
          m_lvl[c] = ~m_lvl[c];
          m_run[c] = 0;
          m_pul[c] = m_lvl[c];
        end
      end
    end
    sb.push_back({m_lvl[0], m_lvl[1], m_pul[0], m_pul[1],
                  m_lvl[2], m_lvl[3], m_pul[2], m_pul[3]});
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got {lvl_r,lvl_c,pls_r,pls_c}=%b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: compares each queued expectation with the DUT outputs.
  always @(negedge clk) begin
    logic [7:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("active_high", {run_o, cont_o, run_p, cont_p}, e[7:4]);
      check("active_low", {al_run_o, al_cont_o, al_run_p, al_cont_p}, e[3:0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset, then idle.
    cyc(3);
    rst_n = 1'b1;
    cyc(20);

    // Clean Run press, long hold, release.
    run_btn = 1'b1;  cyc(30);
    run_btn = 1'b0;  cyc(15);

    // Short Continue glitch, then a hold with a one-cycle release glitch.
    cont_btn = 1'b1; cyc(3);
    cont_btn = 1'b0; cyc(10);
    cont_btn = 1'b1; cyc(12);
    cont_btn = 1'b0; cyc(1);
    cont_btn = 1'b1; cyc(17);
    cont_btn = 1'b0; cyc(15);

    // Simultaneous press.
    run_btn = 1'b1; cont_btn = 1'b1; cyc(15);
    run_btn = 1'b0; cont_btn = 1'b0; cyc(15);

    // Reset while Run is held.
    run_btn = 1'b1; cyc(10);
    rst_n = 1'b0;   cyc(1);
    rst_n = 1'b1;   cyc(15);
    run_btn = 1'b0; cyc(15);

    // Active-low press.
    al_run = 1'b0; cyc(10);
    al_run = 1'b1; cyc(15);

    // Random bouncy buttons with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) run_btn = ~run_btn;
      if ($urandom_range(0, 5) == 0) cont_btn = ~cont_btn;
      if ($urandom_range(0, 5) == 0) al_run = ~al_run;
      if ($urandom_range(0, 5) == 0) al_cont = ~al_cont;
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    run_btn = 1'b0; cont_btn = 1'b0; al_run = 1'b1; al_cont = 1'b1;
    cyc(20);

    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
